rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Grants one requester at a time, held until released.
- Encodes the winner as a 3-bit index and drives a one-hot grant vector through a 3-to-8 decoder.
- Sits in front of any shared datapath (bus, memory port, ALU) that a 3-to-8 select decoder gates.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held (used only with HOLD_TIMEOUT_EN); legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i.
- release  input  1  single-cycle pulse from the current owner ending its grant.
- grant  output  8  one-hot grant vector; all-zero when no grant.
- grant_idx  output  3  binary index of the current owner.
- grant_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse on a forced revocation (tied 0 without HOLD_TIMEOUT_EN).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock is clk, reset is rst_n.
- Reset (rst_n low, takes effect immediately): state=IDLE, grant=8'h00, grant_idx=3'd0, grant_valid=0, timeout=0, ptr=3'd0, hold counter=0.
- All outputs are registered.
- grant equals decode(grant_idx) when grant_valid=1, else 8'h00.
- States:
  - IDLE: no owner.
  - BUSY: owner = grant_idx.
- IDLE -> BUSY:
  - Condition: |req=1 at a clock edge.
  - Winner: first set bit searching ptr, ptr+1, ..., ptr+7 (mod 8).
  - grant_valid, grant_idx and grant update at that same edge, so latency is 1 cycle from req sampled high to grant visible.
- IDLE with req=0: stay in IDLE, outputs unchanged at 0.
- BUSY -> IDLE triggers:
  - release=1, or
  - req[grant_idx]=0 (treated as an implicit release), or
  - timeout (optional feature).
- On BUSY -> IDLE, at the same edge:
  - grant_valid=0, grant=0.
  - ptr = grant_idx+1 mod 8 (7 wraps to 0).
  - grant_idx keeps its last value.
- Dead cycle: exactly one cycle with grant=0 between consecutive grants, even when other requests are pending.
- BUSY, no release: hold. Changes on other req bits are ignored.
- release while in IDLE: ignored.
- release and req[grant_idx] drop in the same cycle: a single release, no side effects.
- Fairness: a continuously asserted request is granted within 8 grants.
- Reset asserted mid-grant: immediate return to the reset values; ptr returns to 0.

Optional Feature:
- Macro: HOLD_TIMEOUT_EN.
- Defined:
  - Hold counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD-1 with no release, the next edge forces BUSY -> IDLE and pulses timeout=1 for one cycle.
  - ptr advances as for a normal release.
  - A release on the same edge as the timeout takes priority: no timeout pulse.
- Not defined:
  - No counter is instantiated; timeout is constant 0.
  - A grant may be held indefinitely.

Decomposition:
- Shared package/include holds:
  - state encodings: ST_IDLE=1'b0, ST_BUSY=1'b1.
  - NUM_REQ=8, IDX_W=3.
  - Default MAX_HOLD.
- One natural sub-module: the existing decoder3to8, instantiated to produce grant from grant_idx, with its output gated by grant_valid.
- The priority search is a combinational function inside rr_arbiter8.

Test Plan:
- Reset check: rst_n=0 with req=8'hFF -> grant=0, grant_valid=0, grant_idx=0. After release of reset, 1 cycle later grant=8'h01, grant_idx=0.
- Round-robin sequence: req=8'hFF held, release pulsed 2 cycles after each grant. Required grant order: 01,02,04,...,80, then 01 (wrap). Exactly one zero-grant cycle between grants.
- Sparse requests: ptr=3 (after owner 2), req=8'h05 -> grant=8'h01 (wraps past 3..7). Then req=8'h04 -> grant=8'h04 after release.
- Implicit release and IDLE release: owner 5 drops req[5] -> grant_valid falls next edge, ptr=6. A release pulse in IDLE changes nothing.
- Async reset mid-grant: grant=8'h10 active, rst_n pulled low between edges -> outputs 0 immediately. After reset, req=8'h18 -> grant=8'h08 (ptr reset to 0).
- HOLD_TIMEOUT_EN, MAX_HOLD=4: owner holds without release -> grant stays 4 cycles, then timeout=1 for one cycle with grant=0. Next requester granted after the dead cycle. A release on the 4th cycle -> timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared constants and state encoding for the 8-way
// round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int NUM_REQ      = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter8_decoder3to8.sv
// decoder3to8: binary 3-bit select to one-hot 8-bit vector.
//   sel : binary index
//   dout: one-hot output, bit sel set
module decoder3to8 (
  input  logic [2:0] sel,
  output logic [7:0] dout
);

  always_comb begin
    dout      = 8'h00;
    dout[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter sharing one resource among 8 requesters.
// A grant is held until the owner releases it (explicit pulse or by
// dropping its request); one dead cycle separates consecutive grants.
//
// Ports:
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   req[7:0]    : request vector, bit i = requester i
//   rel         : single-cycle release pulse from the current owner
//   grant[7:0]  : one-hot grant, zero when no owner
//   grant_idx   : binary index of the current/last owner
//   grant_valid : high while a grant is active
//   timeout     : one-cycle pulse on forced revocation
//
// Optional build macro HOLD_TIMEOUT_EN: adds a hold counter that revokes
// a grant after MAX_HOLD cycles. Without it timeout is tied 0.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rel,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n, idx_n;
  logic               vld_n, tmo_n;
  logic               owner_rel, hold_expired;
  logic [NUM_REQ-1:0] dec_out;

  // First set bit searching ptr, ptr+1, ... (mod 8).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] c;
    logic             found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = p + IDX_W'(i);
      if (!found && r[c]) begin
        rr_pick = c;
        found   = 1'b1;
      end
    end
  endfunction

`ifdef HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  // Held at 0 while idle so it reads 0 on the first BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                hold_cnt <= '0;
    else if (state == ST_IDLE) hold_cnt <= '0;
    else                       hold_cnt <= hold_cnt + 1'b1;
  end

  assign hold_expired = (state == ST_BUSY) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
  assign hold_expired = 1'b0;
`endif

  // A dropped owner request counts as a release.
  assign owner_rel = rel || !req[grant_idx];

  always_comb begin
    state_n = state;
    idx_n   = grant_idx;
    vld_n   = grant_valid;
    ptr_n   = ptr;
    tmo_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_n = ST_BUSY;
          idx_n   = rr_pick(req, ptr);
          vld_n   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (owner_rel || hold_expired) begin
          state_n = ST_IDLE;
          vld_n   = 1'b0;
          ptr_n   = grant_idx + 3'd1;
          // Release on the same edge wins: no timeout pulse.
          tmo_n   = !owner_rel;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Decode the next index so grant is registered alongside grant_idx.
  decoder3to8 u_dec (
    .sel  (idx_n),
    .dout (dec_out)
  );

  logic tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      grant       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant_idx   <= idx_n;
      grant_valid <= vld_n;
      grant       <= vld_n ? dec_out : '0;
      tmo_q       <= tmo_n;
    end
  end

`ifdef HOLD_TIMEOUT_EN
  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

`ifdef HOLD_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter8 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .rel         (rel),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'hFF; rel = 1'b0;
    #12;
    total++; if (grant !== 8'h00) begin bad++; $display("FAIL rst_grant got=%h exp=00", grant); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", grant_valid); end
    total++; if (grant_idx !== 3'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", grant_idx); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (grant !== 8'h01 || grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
      bad++; $display("FAIL rst_first_grant got=%h/%0d/%b exp=01/0/1", grant, grant_idx, grant_valid); end
  endtask

  // Owner k granted, hold one more cycle, release, dead cycle, next owner.
  task automatic test_round_robin();
    logic [7:0] exp;
    for (int k = 0; k < 8; k++) begin
      exp = 8'h01 << k;
      total++; if (grant !== exp || grant_idx !== 3'(k)) begin
        bad++; $display("FAIL rr_grant k=%0d got=%h/%0d exp=%h/%0d", k, grant, grant_idx, exp, k); end
      tick();
      total++; if (grant !== exp) begin bad++; $display("FAIL rr_hold k=%0d got=%h exp=%h", k, grant, exp); end
      rel = 1'b1;
      tick();
      rel = 1'b0;
      total++; if (grant !== 8'h00 || grant_valid !== 1'b0) begin
        bad++; $display("FAIL rr_dead k=%0d got=%h/%b exp=00/0", k, grant, grant_valid); end
      tick();
    end
    total++; if (grant !== 8'h01) begin bad++; $display("FAIL rr_wrap got=%h exp=01", grant); end
    req = 8'h00;
    tick();  // implicit release of owner 0 -> ptr=1
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rr_drop got=%b exp=0", grant_valid); end
  endtask

  task automatic test_sparse();
    req = 8'h04;
    tick();
    total++; if (grant !== 8'h04) begin bad++; $display("FAIL sp_own2 got=%h exp=04", grant); end
    req = 8'h05; rel = 1'b1;
    tick();  // ptr=3
    rel = 1'b0;
    total++; if (grant !== 8'h00) begin bad++; $display("FAIL sp_dead got=%h exp=00", grant); end
    tick();
    total++; if (grant !== 8'h01 || grant_idx !== 3'd0) begin
      bad++; $display("FAIL sp_wrap got=%h/%0d exp=01/0", grant, grant_idx); end
    req = 8'h04; rel = 1'b1;
    tick();
    rel = 1'b0;
    tick();
    total++; if (grant !== 8'h04) begin bad++; $display("FAIL sp_after_rel got=%h exp=04", grant); end
    req = 8'h00;
    tick();  // ptr=3
  endtask

  task automatic test_implicit_release();
    req = 8'h20;
    tick();
    total++; if (grant !== 8'h20 || grant_idx !== 3'd5) begin
      bad++; $display("FAIL ir_own5 got=%h/%0d exp=20/5", grant, grant_idx); end
    req = 8'h00;
    tick();
    total++; if (grant_valid !== 1'b0 || grant !== 8'h00 || grant_idx !== 3'd5) begin
      bad++; $display("FAIL ir_drop got=%h/%0d/%b exp=00/5/0", grant, grant_idx, grant_valid); end
    rel = 1'b1;
    tick();
    rel = 1'b0;
    total++; if (grant_valid !== 1'b0 || grant !== 8'h00 || timeout !== 1'b0) begin
      bad++; $display("FAIL ir_idle_rel got=%h/%b exp=00/0", grant, grant_valid); end
    req = 8'h61;  // ptr=6 must pick 6 over 0 and 5
    tick();
    total++; if (grant !== 8'h40 || grant_idx !== 3'd6) begin
      bad++; $display("FAIL ir_ptr6 got=%h/%0d exp=40/6", grant, grant_idx); end
    req = 8'h00;
    tick();  // ptr=7
  endtask

  task automatic test_async_reset();
    req = 8'h10;
    tick();
    total++; if (grant !== 8'h10) begin bad++; $display("FAIL ar_own4 got=%h exp=10", grant); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
      bad++; $display("FAIL ar_immediate got=%h/%0d/%b exp=00/0/0", grant, grant_idx, grant_valid); end
    tick();
    req = 8'h18; rst_n = 1'b1;
    tick();
    total++; if (grant !== 8'h08 || grant_idx !== 3'd3) begin
      bad++; $display("FAIL ar_ptr0 got=%h/%0d exp=08/3", grant, grant_idx); end
    req = 8'h00;
    tick();  // ptr=4
  endtask

`ifdef HOLD_TIMEOUT_EN
  task automatic test_timeout();
    req = 8'h02;
    tick();
    for (int c = 1; c <= 4; c++) begin
      total++; if (grant !== 8'h02 || timeout !== 1'b0) begin
        bad++; $display("FAIL to_hold c=%0d got=%h/%b exp=02/0", c, grant, timeout); end
      tick();
    end
    total++; if (grant !== 8'h00 || timeout !== 1'b1) begin
      bad++; $display("FAIL to_pulse got=%h/%b exp=00/1", grant, timeout); end
    tick();
    total++; if (grant !== 8'h02 || timeout !== 1'b0) begin
      bad++; $display("FAIL to_regrant got=%h/%b exp=02/0", grant, timeout); end
    tick(); tick(); tick();
    rel = 1'b1;
    tick();
    rel = 1'b0;
    total++; if (grant !== 8'h00 || timeout !== 1'b0) begin
      bad++; $display("FAIL to_rel_prio got=%h/%b exp=00/0", grant, timeout); end
    req = 8'h00;
    tick();
  endtask
`else
  // Grant held indefinitely; other request bits are ignored while busy.
  task automatic test_hold();
    req = 8'h02;
    tick();
    for (int c = 0; c < 20; c++) begin
      total++; if (grant !== 8'h02 || timeout !== 1'b0) begin
        bad++; $display("FAIL hold c=%0d got=%h/%b exp=02/0", c, grant, timeout); end
      req = 8'h02 | (8'($urandom) & 8'hFD);
      tick();
    end
    req = 8'h00; rel = 1'b1;  // release and request drop together
    tick();
    rel = 1'b0;
    total++; if (grant !== 8'h00 || grant_valid !== 1'b0) begin
      bad++; $display("FAIL hold_end got=%h/%b exp=00/0", grant, grant_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_sparse();
    test_implicit_release();
    test_async_reset();
`ifdef HOLD_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
